writeback_stage: RTL and testbench

MEM/WB pipeline register and result-select logic for the 5-stage RV32I core.
- It is the producer side of the register-file write port: it drives rd, wd and RegWrite into the register file.
- It also provides a same-cycle bypass for decode-stage operand reads.
- It performs load-data lane extraction and sign/zero extension, and keeps the 64-bit retired-instruction counter.

---
 rtl/core_pkg.sv | 28 ++
 rtl/writeback_stage_if.sv | 46 ++++
 rtl/load_extend.sv | 46 ++++
 rtl/writeback_stage.sv | 85 ++++++++
 tb/tb_writeback_stage.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_pkg
// Description : Shared RV32I core types: result-select encoding, load funct3
//               codes and default datapath widths.
// Revision    : 1.0
// ============================================================================
package core_pkg;

   localparam int XLEN_DEF   = 32;
   localparam int REG_AW_DEF = 5;
   localparam int CNT_W_DEF  = 64;

   typedef enum logic [1:0] {
      RES_ALU  = 2'b00,
      RES_LOAD = 2'b01,
      RES_PC4  = 2'b10,
      RES_IMM  = 2'b11
   } result_src_e;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

endpackage
`default_nettype wire

// File: rtl/writeback_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : writeback_stage_if
// Description : MEM->WB bundle plus register-file write / bypass port.
// Revision    : 1.0
// ============================================================================
interface writeback_stage_if #(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5,
   parameter int CNT_W  = 64
);
   logic              stall;
   logic              flush;
   logic              m_valid;
   logic              m_reg_write;
   logic [REG_AW-1:0] m_rd;
   logic [1:0]        m_result_src;
   logic [XLEN-1:0]   m_alu_result;
   logic [XLEN-1:0]   m_pc_plus4;
   logic [XLEN-1:0]   m_imm;
   logic [XLEN-1:0]   m_load_word;
   logic [2:0]        m_funct3;
   logic [1:0]        m_addr_lo;

   logic [REG_AW-1:0] rd;
   logic [XLEN-1:0]   wd;
   logic              RegWrite;
   logic              wb_valid;
   logic              fwd_valid;
   logic [REG_AW-1:0] fwd_rd;
   logic [XLEN-1:0]   fwd_data;
   logic [CNT_W-1:0]  instret;

   modport master (
      output stall, flush, m_valid, m_reg_write, m_rd, m_result_src,
             m_alu_result, m_pc_plus4, m_imm, m_load_word, m_funct3, m_addr_lo,
      input  rd, wd, RegWrite, wb_valid, fwd_valid, fwd_rd, fwd_data, instret
   );

   modport slave (
      input  stall, flush, m_valid, m_reg_write, m_rd, m_result_src,
             m_alu_result, m_pc_plus4, m_imm, m_load_word, m_funct3, m_addr_lo,
      output rd, wd, RegWrite, wb_valid, fwd_valid, fwd_rd, fwd_data, instret
   );
endinterface
`default_nettype wire

// File: rtl/load_extend.sv
`default_nettype none
// ============================================================================
// Module      : load_extend
// Description : Combinational load lane extraction and sign/zero extension.
// Revision    : 1.0
// ============================================================================
module load_extend
   import core_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic [XLEN-1:0] i_word,
   input  logic [2:0]      i_funct3,
   input  logic [1:0]      i_addr_lo,
   output logic [XLEN-1:0] o_ext
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte = i_word[7:0];
      case (i_addr_lo)
         2'd1:    w_byte = i_word[15:8];
         2'd2:    w_byte = i_word[23:16];
         2'd3:    w_byte = i_word[31:24];
         default: w_byte = i_word[7:0];
      endcase
   end

   // Halfword lane ignores the low offset bit.
   assign w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];

   always_comb begin
      o_ext = i_word;
      case (i_funct3)
         F3_LB:   o_ext = {{(XLEN-8){w_byte[7]}}, w_byte};
         F3_LBU:  o_ext = {{(XLEN-8){1'b0}}, w_byte};
         F3_LH:   o_ext = {{(XLEN-16){w_half[15]}}, w_half};
         F3_LHU:  o_ext = {{(XLEN-16){1'b0}}, w_half};
         default: o_ext = i_word;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
// Module      : writeback_stage
// Description : MEM/WB pipeline register, result select, register-file write
//               port with bypass, and retired-instruction counter.
// Revision    : 1.0
// ============================================================================
module writeback_stage
   import core_pkg::*;
#(
   parameter int XLEN   = XLEN_DEF,
   parameter int REG_AW = REG_AW_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   writeback_stage_if.slave bus
);

   logic [XLEN-1:0]   w_load;
   logic [XLEN-1:0]   w_result;
   logic              w_reg_write;
   logic              w_retire;

   logic              r_wb_valid;
   logic              r_reg_write;
   logic [REG_AW-1:0] r_rd;
   logic [XLEN-1:0]   r_wd;
   logic [CNT_W-1:0]  r_instret;

   load_extend #(.XLEN(XLEN)) u_load_extend (
      .i_word    (bus.m_load_word),
      .i_funct3  (bus.m_funct3),
      .i_addr_lo (bus.m_addr_lo),
      .o_ext     (w_load)
   );

   always_comb begin
      w_result = bus.m_alu_result;
      case (result_src_e'(bus.m_result_src))
         RES_LOAD: w_result = w_load;
         RES_PC4:  w_result = bus.m_pc_plus4;
         RES_IMM:  w_result = bus.m_imm;
         default:  w_result = bus.m_alu_result;
      endcase
   end

   // The occupant leaves WB whenever it is not held, including on flush.
   assign w_retire = r_wb_valid & (~bus.stall | bus.flush);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wb_valid  <= 1'b0;
         r_reg_write <= 1'b0;
         r_rd        <= '0;
         r_wd        <= '0;
         r_instret   <= '0;
      end else begin
         if (w_retire) begin
            r_instret <= r_instret + CNT_W'(1);
         end
         if (bus.flush) begin
            r_wb_valid <= 1'b0;
         end else if (!bus.stall) begin
            r_wb_valid  <= bus.m_valid;
            r_rd        <= bus.m_rd;
            r_reg_write <= bus.m_reg_write & bus.m_valid;
            r_wd        <= w_result;
         end
      end
   end

   assign w_reg_write = r_wb_valid & r_reg_write & (r_rd != '0);

   assign bus.rd        = r_rd;
   assign bus.wd        = r_wd;
   assign bus.RegWrite  = w_reg_write;
   assign bus.wb_valid  = r_wb_valid;
   assign bus.fwd_valid = w_reg_write;
   assign bus.fwd_rd    = r_rd;
   assign bus.fwd_data  = r_wd;
   assign bus.instret   = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_writeback_stage
// Description : Self-checking bench for writeback_stage against a behavioural
//               model, with directed scenarios and randomized traffic.
// Revision    : 1.0
// ============================================================================
module tb_writeback_stage;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;
   bit   check_en = 1'b0;

   always #5 clk = ~clk;

   writeback_stage_if #(.XLEN(32), .REG_AW(5), .CNT_W(64)) bus ();

   writeback_stage #(.XLEN(32), .REG_AW(5), .CNT_W(64)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Behavioural model state
   bit          md_valid;
   bit          md_wr;
   int unsigned md_rd;
   int unsigned md_wd;
   longint unsigned md_cnt;

   function automatic int unsigned model_load(int unsigned w, int unsigned f3, int unsigned off);
      int unsigned b, h;
      b = (w >> (8 * off)) & 32'hFF;
      h = (w >> (16 * (off / 2))) & 32'hFFFF;
      case (f3)
         0: return (b >= 128) ? b - 256 : b;
         4: return b;
         1: return (h >= 32768) ? h - 65536 : h;
         5: return h;
         default: return w;
      endcase
   endfunction

   function automatic int unsigned model_select();
      case (bus.m_result_src)
         2'd0: return bus.m_alu_result;
         2'd1: return model_load(bus.m_load_word, bus.m_funct3, bus.m_addr_lo);
         2'd2: return bus.m_pc_plus4;
         default: return bus.m_imm;
      endcase
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         md_valid = 0; md_wr = 0; md_rd = 0; md_wd = 0; md_cnt = 0;
      end else begin
         if (md_valid && (!bus.stall || bus.flush)) md_cnt = md_cnt + 1;
         if (bus.flush) md_valid = 0;
         else if (!bus.stall) begin
            md_valid = bus.m_valid;
            md_rd    = bus.m_rd;
            md_wr    = bus.m_valid && bus.m_reg_write;
            md_wd    = model_select();
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (check_en) begin
         automatic bit exp_we = md_valid && md_wr && (md_rd != 0);
         chk("m_wb_valid", 64'(bus.wb_valid), 64'(md_valid));
         chk("m_rd",       64'(bus.rd),       64'(md_rd));
         chk("m_wd",       64'(bus.wd),       64'(md_wd));
         chk("m_RegWrite", 64'(bus.RegWrite), 64'(exp_we));
         chk("m_fwd_valid",64'(bus.fwd_valid),64'(exp_we));
         chk("m_fwd_rd",   64'(bus.fwd_rd),   64'(md_rd));
         chk("m_fwd_data", 64'(bus.fwd_data), 64'(md_wd));
         chk("m_instret",  bus.instret,       md_cnt);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit v, input bit w, input logic [4:0] r, input logic [1:0] src,
                        input logic [31:0] alu, input logic [31:0] pc4, input logic [31:0] imm,
                        input logic [31:0] word, input logic [2:0] f3, input logic [1:0] off);
      bus.m_valid = v; bus.m_reg_write = w; bus.m_rd = r; bus.m_result_src = src;
      bus.m_alu_result = alu; bus.m_pc_plus4 = pc4; bus.m_imm = imm;
      bus.m_load_word = word; bus.m_funct3 = f3; bus.m_addr_lo = off;
   endtask

   task automatic idle();
      drive(0, 0, 5'd0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0, 3'd0, 2'd0);
   endtask

   task automatic scenario_alu(input logic [63:0] base);
      drive(1, 1, 5'd5, 2'd0, 32'h0000_1234, 32'h0, 32'h0, 32'h0, 3'd0, 2'd0);
      tick();
      chk("alu_rd", 64'(bus.rd), 64'd5);
      chk("alu_wd", 64'(bus.wd), 64'h1234);
      chk("alu_we", 64'(bus.RegWrite), 64'd1);
      chk("alu_fwd_valid", 64'(bus.fwd_valid), 64'd1);
      chk("alu_instret0", bus.instret, base);
      idle();
      tick();
      chk("alu_instret1", bus.instret, base + 1);
   endtask

   logic [63:0] saved;

   initial begin
      bus.stall = 0; bus.flush = 0;
      idle();
      tick(); tick();
      chk("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
      chk("rst_we",       64'(bus.RegWrite), 64'd0);
      chk("rst_wd",       64'(bus.wd), 64'd0);
      chk("rst_instret",  bus.instret, 64'd0);
      rst = 0;
      check_en = 1;

      scenario_alu(64'd0);

      // x0 write suppression
      drive(1, 1, 5'd0, 2'd0, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0, 3'd0, 2'd0);
      tick();
      chk("x0_wb_valid", 64'(bus.wb_valid), 64'd1);
      chk("x0_we", 64'(bus.RegWrite), 64'd0);
      idle();
      tick();
      chk("x0_instret", bus.instret, 64'd2);

      // Load lane extraction on 0x80FF_7F01
      begin
         logic [2:0]  f3s [6] = '{3'b000, 3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
         logic [1:0]  offs[6] = '{2'd1, 2'd3, 2'd2, 2'd2, 2'd0, 2'd3};
         logic [31:0] exps[6] = '{32'h0000_007F, 32'hFFFF_FF80, 32'h0000_00FF,
                                  32'hFFFF_80FF, 32'h0000_7F01, 32'h80FF_7F01};
         for (int i = 0; i < 6; i++) begin
            drive(1, 1, 5'd3, 2'd1, 32'h0, 32'h0, 32'h0, 32'h80FF_7F01, f3s[i], offs[i]);
            tick();
            chk($sformatf("load%0d_wd", i), 64'(bus.wd), 64'(exps[i]));
         end
      end
      idle();
      tick();
      chk("load_instret", bus.instret, 64'd8);

      // JAL held by a 3-cycle stall
      drive(1, 1, 5'd1, 2'd2, 32'h0, 32'h104, 32'h0, 32'h0, 3'd0, 2'd0);
      tick();
      chk("jal_wd", 64'(bus.wd), 64'h104);
      chk("jal_we", 64'(bus.RegWrite), 64'd1);
      drive(1, 1, 5'd9, 2'd0, 32'hAAAA_5555, 32'h0, 32'h0, 32'h0, 3'd0, 2'd0);
      bus.stall = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_wd", 64'(bus.wd), 64'h104);
         chk("stall_rd", 64'(bus.rd), 64'd1);
         chk("stall_we", 64'(bus.RegWrite), 64'd1);
         chk("stall_instret", bus.instret, 64'd8);
      end
      bus.stall = 0;
      idle();
      tick();
      chk("unstall_instret", bus.instret, 64'd9);

      // Flush together with stall
      drive(1, 1, 5'd7, 2'd3, 32'h0, 32'h0, 32'h1234_5000, 32'h0, 3'd0, 2'd0);
      tick();
      drive(1, 1, 5'd8, 2'd0, 32'h0BAD_0BAD, 32'h0, 32'h0, 32'h0, 3'd0, 2'd0);
      bus.stall = 1; bus.flush = 1;
      tick();
      chk("flush_wb_valid", 64'(bus.wb_valid), 64'd0);
      chk("flush_we", 64'(bus.RegWrite), 64'd0);
      chk("flush_instret", bus.instret, 64'd10);
      chk("flush_wd_held", 64'(bus.wd), 64'h1234_5000);
      bus.stall = 0; bus.flush = 0;

      // Reset mid-stall with an occupied stage
      drive(1, 1, 5'd4, 2'd0, 32'h55, 32'h0, 32'h0, 32'h0, 3'd0, 2'd0);
      tick();
      bus.stall = 1;
      rst = 1;
      tick();
      chk("rst2_wb_valid", 64'(bus.wb_valid), 64'd0);
      chk("rst2_rd", 64'(bus.rd), 64'd0);
      chk("rst2_wd", 64'(bus.wd), 64'd0);
      chk("rst2_we", 64'(bus.RegWrite), 64'd0);
      chk("rst2_instret", bus.instret, 64'd0);
      rst = 0; bus.stall = 0;
      scenario_alu(64'd0);

      // Randomized traffic, checked every cycle by the compare process
      for (int i = 0; i < 3000; i++) begin
         rst       = ($urandom_range(0, 199) == 0);
         bus.stall = ($urandom_range(0, 4) == 0);
         bus.flush = ($urandom_range(0, 9) == 0);
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
               ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
               2'($urandom), $urandom, $urandom, $urandom, $urandom,
               3'($urandom), 2'($urandom));
         tick();
      end
      rst = 0; bus.stall = 0; bus.flush = 0;
      idle();
      tick(); tick();
      saved = md_cnt;
      chk("final_instret", bus.instret, saved);

      @(posedge clk);
      check_en = 0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
